// File: rtl/ctrl_pipe_tracker.sv
// Tracks the decoded control word through ID/EX, EX/MEM and MEM/WB, raises the IF/ID stall on
// RAW hazards and inserts bubbles. Define FORWARD_EN to enable EX operand forwarding selects.
module ctrl_pipe_tracker #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_regdst,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [REG_AW-1:0] wb_wreg,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam int unsigned BitRegDst   = 7;
  localparam int unsigned BitAluSrc   = 4;
  localparam int unsigned BitMemRead  = 3;
  localparam int unsigned BitMemWrite = 2;
  localparam int unsigned BitRegWrite = 1;
  localparam int unsigned BitMemToReg = 0;

  logic [CTRL_W-1:0] id_ctrl_clean;
  logic [REG_AW-1:0] id_rs_clean, id_rt_clean, id_rd_clean;

  logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  logic [REG_AW-1:0] idex_rd_q, idex_rd_d;
  // {MemRead, MemWrite, RegWrite, MemtoReg}
  logic [3:0]        exmem_ctrl_q, exmem_ctrl_d;
  logic [REG_AW-1:0] exmem_wreg_q, exmem_wreg_d;
  // {RegWrite, MemtoReg}
  logic [1:0]        memwb_ctrl_q, memwb_ctrl_d;
  logic [REG_AW-1:0] memwb_wreg_q, memwb_wreg_d;

  logic [REG_AW-1:0] ex_wreg;
  logic              hazard;

  // Anything not a definite 1 (including x/z) becomes 0.
  always_comb begin
    id_ctrl_clean = '0;
    id_rs_clean   = '0;
    id_rt_clean   = '0;
    id_rd_clean   = '0;
    for (int i = 0; i < CTRL_W; i++) begin
      if (id_ctrl[i] == 1'b1) id_ctrl_clean[i] = 1'b1;
    end
    for (int i = 0; i < REG_AW; i++) begin
      if (id_rs[i] == 1'b1) id_rs_clean[i] = 1'b1;
      if (id_rt[i] == 1'b1) id_rt_clean[i] = 1'b1;
      if (id_rd[i] == 1'b1) id_rd_clean[i] = 1'b1;
    end
  end

  // Non-writing instructions carry destination 0 so they never match a compare.
  assign ex_wreg = idex_ctrl_q[BitRegWrite] ? (idex_ctrl_q[BitRegDst] ? idex_rd_q : idex_rt_q)
                                            : '0;

`ifdef FORWARD_EN
  logic [REG_AW-1:0] idex_rs_q, idex_rs_d;

  always_comb begin
    hazard = idex_ctrl_q[BitMemRead] && (ex_wreg != '0) &&
             ((ex_wreg == id_rs_clean) || (ex_wreg == id_rt_clean));
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (exmem_ctrl_q[1] && (exmem_wreg_q != '0) && (exmem_wreg_q == idex_rs_q)) begin
      fwd_a = 2'b10;
    end else if (memwb_ctrl_q[1] && (memwb_wreg_q != '0) && (memwb_wreg_q == idex_rs_q)) begin
      fwd_a = 2'b01;
    end
    if (exmem_ctrl_q[1] && (exmem_wreg_q != '0) && (exmem_wreg_q == idex_rt_q)) begin
      fwd_b = 2'b10;
    end else if (memwb_ctrl_q[1] && (memwb_wreg_q != '0) && (memwb_wreg_q == idex_rt_q)) begin
      fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_rs_q <= '0;
    else        idex_rs_q <= idex_rs_d;
  end
`else
  // No WB compare: the register file writes before it reads within a cycle.
  always_comb begin
    hazard = 1'b0;
    if (id_rs_clean != '0) begin
      if ((idex_ctrl_q[BitRegWrite] && (ex_wreg == id_rs_clean)) ||
          (exmem_ctrl_q[1] && (exmem_wreg_q == id_rs_clean))) hazard = 1'b1;
    end
    if (id_rt_clean != '0) begin
      if ((idex_ctrl_q[BitRegWrite] && (ex_wreg == id_rt_clean)) ||
          (exmem_ctrl_q[1] && (exmem_wreg_q == id_rt_clean))) hazard = 1'b1;
    end
  end

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // A taken branch kills the ID instruction anyway, so it overrides the stall.
  assign stall = hazard && !flush;

  always_comb begin
    idex_ctrl_d = id_ctrl_clean;
    idex_rt_d   = id_rt_clean;
    idex_rd_d   = id_rd_clean;
`ifdef FORWARD_EN
    idex_rs_d   = id_rs_clean;
`endif
    if (flush || stall) begin
      idex_ctrl_d = '0;
      idex_rt_d   = '0;
      idex_rd_d   = '0;
`ifdef FORWARD_EN
      idex_rs_d   = '0;
`endif
    end
    exmem_ctrl_d = {idex_ctrl_q[BitMemRead], idex_ctrl_q[BitMemWrite],
                    idex_ctrl_q[BitRegWrite], idex_ctrl_q[BitMemToReg]};
    exmem_wreg_d = ex_wreg;
    memwb_ctrl_d = exmem_ctrl_q[1:0];
    memwb_wreg_d = exmem_wreg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q  <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      exmem_ctrl_q <= '0;
      exmem_wreg_q <= '0;
      memwb_ctrl_q <= '0;
      memwb_wreg_q <= '0;
    end else begin
      idex_ctrl_q  <= idex_ctrl_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_wreg_q <= exmem_wreg_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_wreg_q <= memwb_wreg_d;
    end
  end

  assign ex_regdst    = idex_ctrl_q[BitRegDst];
  assign ex_aluop     = idex_ctrl_q[6:5];
  assign ex_alusrc    = idex_ctrl_q[BitAluSrc];
  assign mem_memread  = exmem_ctrl_q[3];
  assign mem_memwrite = exmem_ctrl_q[2];
  assign wb_regwrite  = memwb_ctrl_q[1];
  assign wb_memtoreg  = memwb_ctrl_q[0];
  assign wb_wreg      = memwb_wreg_q;

endmodule
